// File: rtl/tx_rs232.sv
// tx_rs232 -- UART/RS232 transmitter.
// Serialises one byte per request into an 8N1 frame: start bit (0), eight
// data bits LSB first, stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: TX_RS232_PARITY_EN. When it is defined, an even
// parity bit is sent between the data bits and the stop bit (8E1 framing).
//
// Ports
//   clk_s   in   system clock, rising edge
//   rst_s   in   synchronous reset, active high
//   iDATA   in   byte to send, sampled only on the accept cycle
//   iSTART  in   send request, accepted when oBUSY=0
//   oTX     out  serial line (registered), idles high
//   oBUSY   out  high while a frame is in progress
//   oDONE   out  one-cycle pulse on the first idle cycle after the stop bit
module tx_rs232 #(
  parameter int CLKS_PER_BIT = 6,
  parameter int CNT_W        = 8
) (
  input  logic       clk_s,
  input  logic       rst_s,
  input  logic [7:0] iDATA,
  input  logic       iSTART,
  output logic       oTX,
  output logic       oBUSY,
  output logic       oDONE
);

`ifdef TX_RS232_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       idx_q, idx_n;
  logic [7:0]       shift_q, shift_n;
  logic             tx_q, tx_n;
  logic             done_q, done_n;
  logic             bit_end;
`ifdef TX_RS232_PARITY_EN
  logic             par_q, par_n;
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  // The line value is decided here for the *next* cycle and registered,
  // so oTX changes exactly on bit boundaries and never glitches.
  always_comb begin
    state_n = state_q;
    cnt_n   = bit_end ? '0 : cnt_q + 1'b1;
    idx_n   = idx_q;
    shift_n = shift_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
`ifdef TX_RS232_PARITY_EN
    par_n   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (iSTART) begin
          state_n = START;
          shift_n = iDATA;
          tx_n    = 1'b0;
`ifdef TX_RS232_PARITY_EN
          par_n   = ^iDATA;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = 3'd0;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef TX_RS232_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            // shift_q[1] becomes shift_q[0] after this shift
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
            idx_n   = idx_q + 3'd1;
          end
        end
      end
`ifdef TX_RS232_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef TX_RS232_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
`ifdef TX_RS232_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign oTX   = tx_q;
  assign oDONE = done_q;
  assign oBUSY = (state_q != IDLE);

endmodule

// File: tb/tb_tx_rs232.sv
// Bench for tx_rs232. Stimulus pushes each byte expected on the line into a
// scoreboard queue; an independent line monitor decodes frames from oTX,
// checks bit lengths, framing and oDONE timing, and pops/compares.
module tb_tx_rs232;
  localparam int C = 6;
`ifdef TX_RS232_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk_s = 1'b0;
  logic       rst_s = 1'b1;
  logic [7:0] iDATA = 8'h00;
  logic       iSTART = 1'b0;
  logic       oTX, oBUSY, oDONE;

  tx_rs232 #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (
    .clk_s(clk_s), .rst_s(rst_s), .iDATA(iDATA), .iSTART(iSTART),
    .oTX(oTX), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 clk_s = ~clk_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line monitor ----------------
  bit              mact = 1'b0;
  int              mcnt = 0;
  logic            ptx  = 1'b1;
  logic            first;
  logic [NB-1:0]   bits;
  logic [7:0]      exp_b;

  always @(negedge clk_s) begin
    if (rst_s) begin
      mact = 1'b0;
    end else begin
      if (mact) mcnt++;
      else if (ptx && !oTX) begin
        mact = 1'b1;
        mcnt = 0;
      end
      if (mact) begin
        if (mcnt < NB*C) begin
          if (mcnt % C == 0) first = oTX;
          if (mcnt % C == C-1) begin
            chk(oTX == first, "bit_stable", int'(oTX), int'(first));
            bits[mcnt / C] = oTX;
          end
        end else begin
          chk(oDONE == 1'b1 && oBUSY == 1'b0, "done_timing",
              int'({oDONE, oBUSY}), 2);
          chk(bits[0] == 1'b0, "start_bit", int'(bits[0]), 0);
          chk(bits[NB-1] == 1'b1, "stop_bit", int'(bits[NB-1]), 1);
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_frame", int'(bits[8:1]), -1);
          end else begin
            exp_b = sb.pop_front();
            chk(bits[8:1] == exp_b, "frame_byte", int'(bits[8:1]), int'(exp_b));
`ifdef TX_RS232_PARITY_EN
            chk(bits[9] == ^exp_b, "parity_bit", int'(bits[9]), int'(^exp_b));
`endif
          end
          mact = 1'b0;
        end
      end else if (oDONE) begin
        chk(1'b0, "spurious_done", 1, 0);
      end
    end
    ptx = rst_s ? 1'b1 : oTX;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input bit push);
    @(negedge clk_s);
    iDATA  = b;
    iSTART = 1'b1;
    if (push) sb.push_back(b);
    @(negedge clk_s);
    iSTART = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!oDONE && k < 2000) begin
      @(negedge clk_s);
      k++;
    end
    if (!oDONE) chk(1'b0, "done_wait_timeout", k, 2000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_s);
  endtask

  initial begin
    int k;
    logic [7:0] bytes5 [4];
    bytes5[0] = 8'h12; bytes5[1] = 8'h34; bytes5[2] = 8'h56; bytes5[3] = 8'h78;

    // reset state
    idle(3);
    chk(oTX == 1'b1, "reset_tx", int'(oTX), 1);
    chk(oBUSY == 1'b0, "reset_busy", int'(oBUSY), 0);
    chk(oDONE == 1'b0, "reset_done", int'(oDONE), 0);
    rst_s = 1'b0;
    idle(2);

    // 1: reset mid-frame aborts, no oDONE afterwards
    send(8'h55, 1'b0);
    idle(20);
    rst_s = 1'b1;
    @(negedge clk_s);
    chk(oTX == 1'b1, "abort_tx", int'(oTX), 1);
    chk(oBUSY == 1'b0, "abort_busy", int'(oBUSY), 0);
    chk(oDONE == 1'b0, "abort_done", int'(oDONE), 0);
    idle(4);
    rst_s = 1'b0;
    idle(80);

    // 2: single byte 0xA5, oDONE at accept + NB*C + 1
    send(8'hA5, 1'b1);
    k = 1;
    while (!oDONE && k < 2000) begin
      @(negedge clk_s);
      k++;
    end
    chk(k == NB*C + 1, "a5_done_latency", k, NB*C + 1);
    idle(3);

    // 3: request while busy is dropped
    send(8'hFF, 1'b1);
    idle(15);
    send(8'h3C, 1'b0);
    wait_done();
    idle(NB*C + 20);
    chk(oBUSY == 1'b0, "ignored_busy", int'(oBUSY), 0);

    // 4: iSTART held high, back-to-back frames
    @(negedge clk_s);
    iDATA  = 8'h00;
    iSTART = 1'b1;
    sb.push_back(8'h00);
    @(negedge clk_s);
    wait_done();
    iDATA = 8'h81;
    sb.push_back(8'h81);
    @(negedge clk_s);
    chk(oTX == 1'b0, "b2b_start", int'(oTX), 0);
    chk(oBUSY == 1'b1, "b2b_busy", int'(oBUSY), 1);
    idle(3);
    iSTART = 1'b0;
    iDATA  = 8'h55;       // mid-frame change must not matter
    wait_done();
    idle(3);

    // 5: sequence of bytes
    for (int i = 0; i < 4; i++) begin
      send(bytes5[i], 1'b1);
      wait_done();
    end
    idle(NB*C + 10);

    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
